bayer_line_pair: RTL

Upstream companion of the RAW-to-YUV422 converter. It accepts a single stream of packed Bayer words from the camera capture path and buffers each even line in an internal line RAM. While the following odd line arrives, it replays the stored even line, so the converter receives vertically aligned word pairs (even row on `DATA_OUT1`, odd row on `DATA_OUT2`) qualified by `RD_EN`.

---
 rtl/bayer_line_pair.sv | 134 +++++++++++++
 1 files changed

// File: rtl/bayer_line_pair.sv
// Buffers each even Bayer line in a line RAM and replays it alongside the following odd line.
// Optional BAYER_PAIR_CNT_EN builds the PAIR_CNT output and its counter.
module bayer_line_pair #(
  parameter int unsigned ADDR_WIDTH     = 10,
  parameter int unsigned DATA_WIDTH_RAW = 16
) (
  input  logic                      CLK,
  input  logic                      RESET,
  input  logic                      FRAME_START,
  input  logic                      PIX_VALID,
  input  logic [DATA_WIDTH_RAW-1:0] PIX_DATA,
  input  logic                      PIX_LAST,
  output logic                      RD_EN,
  output logic [DATA_WIDTH_RAW-1:0] DATA_OUT1,
  output logic [DATA_WIDTH_RAW-1:0] DATA_OUT2,
  output logic                      LINE_OVF,
  output logic                      LEN_ERR
`ifdef BAYER_PAIR_CNT_EN
  ,
  output logic [15:0]               PAIR_CNT
`endif
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_FILL = 2'd1;
  localparam logic [1:0] ST_PAIR = 2'd2;

  logic [DATA_WIDTH_RAW-1:0] r_mem [2**ADDR_WIDTH];

  logic [1:0]          r_state;
  logic [ADDR_WIDTH:0] r_addr;
  logic [ADDR_WIDTH:0] r_len;

  logic [1:0]          w_state_d;
  logic [ADDR_WIDTH:0] w_addr_d;
  logic [ADDR_WIDTH:0] w_len_d;
  logic                w_wr_en;
  logic                w_rd_en;
  logic                w_ovf;
  logic                w_len_err;
  logic                w_pair_done;

  always_comb begin
    w_state_d   = r_state;
    w_addr_d    = r_addr;
    w_len_d     = r_len;
    w_wr_en     = 1'b0;
    w_rd_en     = 1'b0;
    w_ovf       = 1'b0;
    w_len_err   = 1'b0;
    w_pair_done = 1'b0;
    if (FRAME_START) begin
      // Frame restart wins over any coincident word, which is dropped.
      w_state_d = ST_FILL;
      w_addr_d  = '0;
    end else if (PIX_VALID) begin
      case (r_state)
        ST_FILL: begin
          // addr MSB set means the RAM is full; the address parks there.
          if (!r_addr[ADDR_WIDTH]) begin
            w_wr_en  = 1'b1;
            w_addr_d = r_addr + 1'b1;
          end else begin
            w_ovf = 1'b1;
          end
          if (PIX_LAST) begin
            w_state_d = ST_PAIR;
            w_addr_d  = '0;
            w_len_d   = r_addr[ADDR_WIDTH] ? r_addr : r_addr + 1'b1;
          end
        end
        ST_PAIR: begin
          if (r_addr < r_len) begin
            w_rd_en  = 1'b1;
            w_addr_d = r_addr + 1'b1;
          end else begin
            w_len_err = 1'b1;
          end
          if (PIX_LAST) begin
            w_state_d   = ST_FILL;
            w_addr_d    = '0;
            w_pair_done = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (w_wr_en) r_mem[r_addr[ADDR_WIDTH-1:0]] <= PIX_DATA;
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_state   <= ST_IDLE;
      r_addr    <= '0;
      r_len     <= '0;
      RD_EN     <= 1'b0;
      DATA_OUT1 <= '0;
      DATA_OUT2 <= '0;
      LINE_OVF  <= 1'b0;
      LEN_ERR   <= 1'b0;
    end else begin
      r_state  <= w_state_d;
      r_addr   <= w_addr_d;
      r_len    <= w_len_d;
      RD_EN    <= w_rd_en;
      LINE_OVF <= w_ovf;
      LEN_ERR  <= w_len_err;
      if (w_rd_en) begin
        DATA_OUT1 <= r_mem[r_addr[ADDR_WIDTH-1:0]];
        DATA_OUT2 <= PIX_DATA;
      end
    end
  end

`ifdef BAYER_PAIR_CNT_EN
  logic [15:0] r_pair_cnt;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_pair_cnt <= '0;
    end else if (FRAME_START) begin
      r_pair_cnt <= '0;
    end else if (w_pair_done && (r_pair_cnt != 16'hFFFF)) begin
      r_pair_cnt <= r_pair_cnt + 16'd1;
    end
  end

  assign PAIR_CNT = r_pair_cnt;
`endif

endmodule
